transpose_output_collector: RTL and testbench

- Downstream of the transposed-matrix FSM / systolic array: captures each PE's partial sum when that PE's one-hot en_output strobe fires, in wavefront order.
- Quantizes each captured sum to DW bits (arithmetic shift plus signed saturation).
- Streams one tile of NUM_PE words, in PE index order 0..NUM_PE-1, over a valid/ready interface to the output buffer / DMA.

---
 rtl/transpose_output_collector.sv | 219 +++++++++++++++++++++
 tb/tb_transpose_output_collector.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/transpose_output_collector.sv
// ---------------------------------------------------------------------------
// transpose_output_collector
//
// Collects the partial sums of a systolic array as the transposed-matrix FSM
// strobes each PE (one-hot en_output, wavefront order), quantizes every
// captured sum to a DW-bit signed word (arithmetic shift + saturation) and
// streams one tile of NUM_PE words, PE index order 0..NUM_PE-1, over a
// valid/ready interface.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   start      begin a new tile (only honoured in IDLE)
//   en_output  one-hot capture strobe, bit i selects PE i
//   done_in    FSM done counter, value 16 ends the computation early
//   psum_in    flattened partial sums, PE i at [i*PW +: PW]
//   out_data   quantized word for the current read pointer
//   out_valid  out_data is valid (high throughout DRAIN)
//   out_ready  consumer accepts the word
//   busy       collector is not idle
//   tile_done  one-cycle pulse after the last word of a tile transfers
//   err_multi  sticky: en_output had more than one bit set during COLLECT
//   err_late   sticky: en_output was nonzero outside COLLECT
// ---------------------------------------------------------------------------
module transpose_output_collector #(
  parameter int DW     = 16,
  parameter int PW     = 32,
  parameter int NUM_PE = 16,
  parameter int SHIFT  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [NUM_PE-1:0]    en_output,
  input  logic [4:0]           done_in,
  input  logic [NUM_PE*PW-1:0] psum_in,
  output logic [DW-1:0]        out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 tile_done,
  output logic                 err_multi,
  output logic                 err_late
);

  localparam int PTRW = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam int CW   = $clog2(NUM_PE + 1);

  // Saturation bounds, expressed both at output width and at psum width
  localparam logic [DW-1:0] OUT_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] OUT_MIN = {1'b1, {(DW-1){1'b0}}};
  localparam logic signed [PW-1:0] S_MAX = {{(PW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [PW-1:0] S_MIN = {{(PW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DRAIN   = 2'd2
  } state_t;

  // Arithmetic (floor) shift followed by signed saturation to DW bits
  function automatic logic [DW-1:0] quant(input logic signed [PW-1:0] x);
    logic signed [PW-1:0] s;
    s = x >>> SHIFT;
    if (s > S_MAX) begin
      quant = OUT_MAX;
    end else if (s < S_MIN) begin
      quant = OUT_MIN;
    end else begin
      quant = DW'(s);
    end
  endfunction

  state_t             state_q, state_d;
  logic [DW-1:0]      entry_q [NUM_PE];
  logic [DW-1:0]      entry_d [NUM_PE];
  logic [NUM_PE-1:0]  valid_q, valid_d;
  logic [CW-1:0]      cap_cnt_q, cap_cnt_d;
  logic [PTRW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [DW-1:0]      out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;
  logic               tile_done_q, tile_done_d;
  logic               err_multi_q, err_multi_d;
  logic               err_late_q, err_late_d;

  logic [NUM_PE-1:0]  onehot_s;
  logic               cap_hit_s;
  logic               cap_multi_s;
  logic [PTRW-1:0]    cap_idx_s;
  logic [PW-1:0]      psum_sel_s;
  logic [DW-1:0]      cap_word_s;

  // Lowest-set-bit priority select of the capture strobe; only the winning
  // PE's sum is muxed out, so a single quantizer serves all PEs.
  always_comb begin
    onehot_s    = en_output & (~en_output + NUM_PE'(1));
    cap_hit_s   = |en_output;
    cap_multi_s = |(en_output & (en_output - NUM_PE'(1)));
    cap_idx_s   = '0;
    psum_sel_s  = '0;
    for (int i = 0; i < NUM_PE; i++) begin
      cap_idx_s  = cap_idx_s  | (onehot_s[i] ? PTRW'(i) : '0);
      psum_sel_s = psum_sel_s | (onehot_s[i] ? psum_in[i*PW +: PW] : '0);
    end
    cap_word_s = quant(psum_sel_s);
  end

  // Next-state, buffer update and registered-output computation
  always_comb begin
    state_d     = state_q;
    entry_d     = entry_q;
    valid_d     = valid_q;
    cap_cnt_d   = cap_cnt_q;
    rd_ptr_d    = rd_ptr_q;
    tile_done_d = 1'b0;
    err_multi_d = err_multi_q;
    err_late_d  = err_late_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          for (int i = 0; i < NUM_PE; i++) begin
            entry_d[i] = '0;
          end
          valid_d     = '0;
          cap_cnt_d   = '0;
          rd_ptr_d    = '0;
          err_multi_d = 1'b0;
          err_late_d  = 1'b0;
          state_d     = ST_COLLECT;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_COLLECT: begin
        // A repeated capture overwrites the entry but is not counted again
        entry_d[cap_idx_s] = cap_hit_s ? cap_word_s : entry_q[cap_idx_s];
        valid_d[cap_idx_s] = valid_q[cap_idx_s] | cap_hit_s;
        cap_cnt_d   = cap_cnt_q + CW'(cap_hit_s && !valid_q[cap_idx_s]);
        err_multi_d = err_multi_q | cap_multi_s;
        // Last capture and done_in==16 may coincide; the capture above is
        // still stored on this edge.
        if ((cap_cnt_d == CW'(NUM_PE)) || (done_in == 5'd16)) begin
          state_d  = ST_DRAIN;
          rd_ptr_d = '0;
        end else begin
          state_d = ST_COLLECT;
        end
      end

      ST_DRAIN: begin
        if (out_ready) begin
          if (rd_ptr_q == PTRW'(NUM_PE - 1)) begin
            state_d     = ST_IDLE;
            rd_ptr_d    = '0;
            tile_done_d = 1'b1;
          end else begin
            rd_ptr_d = rd_ptr_q + PTRW'(1);
          end
        end else begin
          rd_ptr_d = rd_ptr_q;
        end
      end

      default: begin
        state_d  = ST_IDLE;
        rd_ptr_d = '0;
      end
    endcase

    // Strobes outside COLLECT are dropped and flagged
    err_late_d = err_late_d | ((state_q != ST_COLLECT) && cap_hit_s);

    // Outputs are registered from the next-state view so they line up with
    // state_q/rd_ptr_q in the following cycle.
    out_valid_d = (state_d == ST_DRAIN);
    busy_d      = (state_d != ST_IDLE);
    out_data_d  = (state_d == ST_DRAIN) ? entry_d[rd_ptr_d] : '0;
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      entry_q     <= '{default: '0};
      valid_q     <= '0;
      cap_cnt_q   <= '0;
      rd_ptr_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      tile_done_q <= 1'b0;
      err_multi_q <= 1'b0;
      err_late_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      entry_q     <= entry_d;
      valid_q     <= valid_d;
      cap_cnt_q   <= cap_cnt_d;
      rd_ptr_q    <= rd_ptr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      tile_done_q <= tile_done_d;
      err_multi_q <= err_multi_d;
      err_late_q  <= err_late_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign tile_done = tile_done_q;
  assign err_multi = err_multi_q;
  assign err_late  = err_late_q;

endmodule

// File: tb/tb_transpose_output_collector.sv
// ---------------------------------------------------------------------------
// Scoreboard bench for transpose_output_collector. The stimulus process
// pushes the hand-computed words of each tile into exp_q; a negedge monitor
// pops and compares on every out_valid && out_ready handshake and checks that
// out_data holds across stalls.
// ---------------------------------------------------------------------------
module tb_transpose_output_collector;
  localparam int DW = 16;
  localparam int PW = 32;
  localparam int N  = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [N-1:0]    en_output;
  logic [4:0]      done_in;
  logic [N*PW-1:0] psum_in;
  logic [DW-1:0]   out_data;
  logic            out_valid;
  logic            out_ready;
  logic            busy;
  logic            tile_done;
  logic            err_multi;
  logic            err_late;

  int errors = 0;
  int checks = 0;
  int hs_cnt = 0;
  int td_cnt = 0;

  logic [DW-1:0] exp_q[$];
  logic [N-1:0]  en_seq[$];
  logic [PW-1:0] pv [N];

  logic          stall_prev = 1'b0;
  logic [DW-1:0] data_prev  = '0;

  always #5 clk = ~clk;

  transpose_output_collector #(.DW(DW), .PW(PW), .NUM_PE(N), .SHIFT(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .en_output(en_output),
    .done_in(done_in), .psum_in(psum_in), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
    .tile_done(tile_done), .err_multi(err_multi), .err_late(err_late)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: scoreboard pop on handshake, hold check across stalls
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (stall_prev) chk("hold_data", 32'(out_data), 32'(data_prev));
      if (out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got 0x%0h with empty scoreboard", out_data);
        end else begin
          chk($sformatf("word%0d", hs_cnt), 32'(out_data), 32'(exp_q.pop_front()));
        end
        hs_cnt++;
      end
      stall_prev = !out_ready;
      data_prev  = out_data;
    end else begin
      stall_prev = 1'b0;
    end
    if (tile_done) td_cnt++;
  end

  task automatic drive_psum();
    for (int i = 0; i < N; i++) psum_in[i*PW +: PW] = pv[i];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run one tile: en_seq is applied one entry per cycle, then optional
  // done_in==16, then drain with optional 1,0,0,1 backpressure and an
  // optional late strobe during DRAIN.
  task automatic run_tile(input bit send_done, input bit bp, input logic [N-1:0] late_en,
                          input bit exp_multi, input bit exp_late);
    int cyc;
    hs_cnt = 0;
    td_cnt = 0;
    drive_psum();
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("errs_cleared", 32'({err_multi, err_late}), 32'd0);
    while (en_seq.size() > 0) begin
      en_output = en_seq.pop_front();
      tick();
    end
    en_output = '0;
    if (send_done) begin
      done_in = 5'd16;
      tick();
      done_in = 5'd0;
    end
    chk("valid_in_drain", 32'(out_valid), 32'd1);
    cyc = 0;
    while (!tile_done && cyc < 200) begin
      if (bp) out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      else    out_ready = 1'b1;
      en_output = (cyc == 2) ? late_en : '0;
      tick();
      cyc++;
    end
    en_output = '0;
    out_ready = 1'b1;
    chk("tile_done_seen", 32'(tile_done), 32'd1);
    if (!bp) chk("drain_cycles", 32'(cyc), 32'd16);
    chk("handshakes", 32'(hs_cnt), 32'd16);
    chk("err_multi", 32'(err_multi), 32'(exp_multi));
    chk("err_late", 32'(err_late), 32'(exp_late));
    tick();
    chk("tile_done_pulse", 32'(tile_done), 32'd0);
    chk("tile_done_count", 32'(td_cnt), 32'd1);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic set_nominal();
    for (int i = 0; i < N; i++) pv[i] = 32'((i + 1) * 256);
  endtask

  logic [PW-1:0] q_in  [5];
  logic [DW-1:0] q_exp [5];

  initial begin
    q_in[0] = 32'd74565;     q_exp[0] = 16'h0123;
    q_in[1] = 32'h0100_0000; q_exp[1] = 16'h7FFF;
    q_in[2] = 32'hFF00_0000; q_exp[2] = 16'h8000;
    q_in[3] = 32'hFFFF_FFFF; q_exp[3] = 16'hFFFF;
    q_in[4] = 32'hFFFF_FF00; q_exp[4] = 16'hFFFF;

    rst_n = 1'b0; start = 1'b0; en_output = '0; done_in = 5'd0;
    psum_in = '0; out_ready = 1'b0;
    repeat (2) tick();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tile_done", 32'(tile_done), 32'd0);
    chk("rst_errs", 32'({err_multi, err_late}), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_busy", 32'(busy), 32'd0);

    // Nominal tile
    set_nominal();
    for (int i = 0; i < N; i++) begin
      en_seq.push_back(N'(1) << i);
      exp_q.push_back(16'(i + 1));
    end
    run_tile(1'b0, 1'b0, '0, 1'b0, 1'b0);

    // Quantization cases on PE0, one per tile
    for (int c = 0; c < 5; c++) begin
      pv = '{default: '0};
      pv[0] = q_in[c];
      en_seq.push_back(16'h0001);
      exp_q.push_back(q_exp[c]);
      for (int i = 1; i < N; i++) exp_q.push_back(16'h0000);
      run_tile(1'b1, 1'b0, '0, 1'b0, 1'b0);
    end

    // Early end after PEs 0..3
    set_nominal();
    for (int i = 0; i < N; i++) exp_q.push_back((i < 4) ? 16'(i + 1) : 16'h0000);
    for (int i = 0; i < 4; i++) en_seq.push_back(N'(1) << i);
    run_tile(1'b1, 1'b0, '0, 1'b0, 1'b0);

    // Backpressure 1,0,0,1 with a full tile
    set_nominal();
    for (int i = 0; i < N; i++) begin
      en_seq.push_back(N'(1) << i);
      exp_q.push_back(16'(i + 1));
    end
    run_tile(1'b0, 1'b1, '0, 1'b0, 1'b0);

    // Multi-bit strobe (PE0 wins) plus a late strobe during DRAIN
    set_nominal();
    en_seq.push_back(16'h0005);
    exp_q.push_back(16'h0001);
    for (int i = 1; i < N; i++) exp_q.push_back(16'h0000);
    run_tile(1'b1, 1'b0, 16'h0002, 1'b1, 1'b1);

    // Reset mid-DRAIN at rd_ptr=7
    set_nominal();
    drive_psum();
    hs_cnt = 0;
    td_cnt = 0;
    for (int i = 0; i < N; i++) exp_q.push_back(16'(i + 1));
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("rst_errs_cleared", 32'({err_multi, err_late}), 32'd0);
    for (int i = 0; i < N; i++) begin
      en_output = N'(1) << i;
      tick();
    end
    en_output = '0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 100 && hs_cnt < 7; cyc++) tick();
    chk("pre_reset_handshakes", 32'(hs_cnt), 32'd7);
    out_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_tile_done", 32'(tile_done), 32'd0);
    exp_q.delete();
    out_ready = 1'b1;
    tick();
    chk("postrst_valid", 32'(out_valid), 32'd0);
    chk("postrst_tile_done", 32'(td_cnt), 32'd0);

    // Fresh tile after reset
    for (int i = 0; i < N; i++) begin
      en_seq.push_back(N'(1) << i);
      exp_q.push_back(16'(i + 1));
    end
    run_tile(1'b0, 1'b0, '0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
